inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
// - Producer side of the IF->IQ interface: fetches one 32-bit instruction per memory transaction and pushes it into IQ.
// - Owns the architectural fetch PC and a direct-mapped BTB with 2-bit counters. Redirects to roll_PC on roll.
// - Sits between the memory controller (instruction port) and IQ. The ROB trains the BTB at branch commit.
// PARAMETERS
// - RESET_PC   32'h0  fetch PC after reset
// - BTB_IDX_W  4      BTB index width; 2**BTB_IDX_W entries, index = PC[BTB_IDX_W+1:2], tag = PC[31:BTB_IDX_W+2]
// PORTS
// - clk             in   1   clock; all state updates on posedge
// - rst             in   1   asynchronous, active-low reset (asserted when 0)
// - rdy             in   1   global ready; when 0, all state frozen except roll handling
// - roll            in   1   mispredict flush; IQ clears in the same cycle
// - roll_PC         in   32  restart PC, valid with roll
// - mem_req         out  1   instruction read request; level, held until mem_done
// - mem_addr        out  32  read address, stable while mem_req=1
// - mem_done        in   1   one-cycle pulse: mem_inst valid
// - mem_inst        in   32  fetched instruction
// - IQ_full         in   1   IQ has no free slot (registered in IQ)
// - IF_flag         out  1   one-cycle push strobe to IQ
// - IF_inst         out  32  pushed instruction
// - IF_PC           out  32  PC of pushed instruction
// - IF_BTB_PC       out  32  predicted next PC (target if predicted taken, else PC+4)
// - IF_BTB_predict  out  1   1 = predicted taken
// - ROB_br_flag     in   1   BTB update strobe
// - ROB_br_PC       in   32  committed branch PC
// - ROB_br_target   in   32  resolved taken target
// - ROB_br_taken    in   1   actual outcome
// BEHAVIOUR
// - Reset (rst=0, async): PC=RESET_PC; state=IDLE; mem_req=0; IF_flag=0; all BTB valid=0, counters=2'b01; IF_* data=0.
// - FSM IDLE: if rdy && !IQ_full -> mem_req<=1, mem_addr<=PC, go WAIT. Otherwise stay.
// - FSM WAIT: on mem_done -> mem_req<=0. Also IF_flag<=1, IF_inst<=mem_inst, IF_PC<=PC.
//   IF_BTB_* <= BTB lookup of PC. PC<=IF_BTB_PC value. Go IDLE.
// - Push latency: IF_flag rises the cycle after the mem_done edge. IF_flag is never high on two consecutive cycles.
// - Only one request is outstanding. Issue requires !IQ_full, so a slot is guaranteed at push; no hold state.
// - IF_flag=1 while IQ_full=1 is a protocol violation. Assert in sim.
// - FSM DISCARD: entered on roll while WAIT and mem_done=0. Keep mem_req=1 until mem_done, drop data, then go IDLE.
// - roll (any state, ignores rdy): PC<=roll_PC; IF_flag<=0. WAIT -> DISCARD. WAIT with mem_done same cycle -> data dropped, IDLE.
//   IDLE/DISCARD stay put (DISCARD still awaits mem_done). roll has priority over mem_done and over a new issue.
// - roll during DISCARD: PC updated to the newer roll_PC; still discard the pending response.
// - rdy=0: no issue, no push (IF_flag<=0), FSM holds. mem_done while rdy=0 is not allowed (memory controller shares rdy).
// - BTB lookup is combinational on PC; hit = valid && tag match. Predict taken = hit && cnt[1].
// - BTB update on ROB_br_flag: write tag, valid=1, target<=ROB_br_target when taken.
//   Counter saturates at 00/11: +1 if taken, -1 if not. A tag miss reallocates: cnt=taken?2'b10:2'b01.
// - Lookup and update to the same index in one cycle: lookup sees the pre-update entry.
// - PC arithmetic: 32-bit, PC+4 wraps modulo 2^32; PC[1:0] carried as given, not checked.
// STRUCTURE
// - Add to define.v: `BTB_IDX_W, `BTB_SIZE, FSM state encodings (IF_IDLE/IF_WAIT/IF_DISCARD), counter init values.
// - One sub-module: btb (storage, combinational lookup, clocked update, async-low reset of valid/cnt). FSM and PC stay in inst_fetch.
// TESTING
// - Reset with RESET_PC=0; memory returns 32'h00000013 after 3 cycles -> mem_addr=0, then IF_flag pulse with IF_PC=0, IF_BTB_PC=4, predict=0.
// - IQ_full=1 held 10 cycles -> mem_req stays 0. Deassert -> mem_req=1 next cycle at the current PC.
// - Train BTB: two ROB updates PC=0x10, target=0x40, taken -> next fetch at 0x10 gives IF_BTB_predict=1, IF_BTB_PC=0x40, next mem_addr=0x40.
// - roll (roll_PC=0x100) two cycles before mem_done -> no IF_flag for that response. The next request has mem_addr=0x100.
// - roll and mem_done same cycle -> no push. Next mem_addr=roll_PC. Repeat with a second roll during DISCARD -> the latest roll_PC is used.
// - rdy=0 mid-WAIT, then mem_done after rdy returns -> exactly one push with the correct PC. Async rst mid-WAIT -> outputs at reset values immediately.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states, BTB
// geometry defaults and 2-bit branch counter encodings.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0;
  localparam int          BTB_IDX_W_DEF = 4;

  localparam logic [1:0] CNT_INIT     = 2'b01;
  localparam logic [1:0] CNT_ALLOC_T  = 2'b10;
  localparam logic [1:0] CNT_ALLOC_NT = 2'b01;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-port bus between the fetch unit (master) and the memory
// controller (slave): level request held until a one-cycle done pulse.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;

  modport master (output mem_req, mem_addr, input  mem_done, mem_inst);
  modport slave  (input  mem_req, mem_addr, output mem_done, mem_inst);
endinterface

// File: rtl/inst_fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC,
// clocked training from committed branches.
module inst_fetch_btb
  import inst_fetch_pkg::*;
#(
  parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_predict,
  output logic [31:0] o_next_pc,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 30 - BTB_IDX_W;

  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [31:0]          r_target [ENTRIES];
  logic [1:0]           r_cnt    [ENTRIES];
  logic [ENTRIES-1:0]   r_valid;

  logic [BTB_IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]     w_lk_tag, w_up_tag;
  logic                 w_lk_hit, w_up_hit;
  logic                 w_unused;

  assign w_lk_idx = i_lookup_pc[BTB_IDX_W+1:2];
  assign w_lk_tag = i_lookup_pc[31:BTB_IDX_W+2];
  assign w_up_idx = i_upd_pc[BTB_IDX_W+1:2];
  assign w_up_tag = i_upd_pc[31:BTB_IDX_W+2];
  assign w_unused = &{1'b0, i_upd_pc[1:0]};

  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign o_predict = w_lk_hit && r_cnt[w_lk_idx][1];
  assign o_next_pc = o_predict ? r_target[w_lk_idx] : i_lookup_pc + 32'd4;

  // A write to the looked-up index lands at the edge, so lookup sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    end else if (i_upd_en) begin
      r_valid[w_up_idx] <= 1'b1;
      r_cnt[w_up_idx]   <= w_up_hit ? cnt_next(r_cnt[w_up_idx], i_upd_taken)
                                    : (i_upd_taken ? CNT_ALLOC_T : CNT_ALLOC_NT);
    end
  end

  // NOTE: tag/target arrays carry no reset; valid gates every read, so they stay plain storage.
  always_ff @(posedge clk) begin
    if (i_upd_en) begin
      r_tag[w_up_idx] <= w_up_tag;
      if (i_upd_taken) r_target[w_up_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, keeps one memory read outstanding and
// pushes each returned instruction with its BTB prediction into the IQ.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         roll,
  input  logic [31:0]  roll_PC,
  inst_fetch_if.master mem_bus,
  input  logic         IQ_full,
  output logic         IF_flag,
  output logic [31:0]  IF_inst,
  output logic [31:0]  IF_PC,
  output logic [31:0]  IF_BTB_PC,
  output logic         IF_BTB_predict,
  input  logic         ROB_br_flag,
  input  logic [31:0]  ROB_br_PC,
  input  logic [31:0]  ROB_br_target,
  input  logic         ROB_br_taken
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        w_predict;
  logic [31:0] w_next_pc;

  assign mem_bus.mem_req  = r_mem_req;
  assign mem_bus.mem_addr = r_mem_addr;

  inst_fetch_btb #(.BTB_IDX_W(BTB_IDX_W)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_pc  (r_pc),
    .o_predict    (w_predict),
    .o_next_pc    (w_next_pc),
    .i_upd_en     (ROB_br_flag & rdy),
    .i_upd_pc     (ROB_br_PC),
    .i_upd_target (ROB_br_target),
    .i_upd_taken  (ROB_br_taken)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IF_IDLE;
      r_pc           <= RESET_PC;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      IF_flag        <= 1'b0;
      IF_inst        <= '0;
      IF_PC          <= '0;
      IF_BTB_PC      <= '0;
      IF_BTB_predict <= 1'b0;
    end else if (roll) begin
      // A response landing with the roll is dropped; otherwise an in-flight read is discarded later.
      r_pc    <= roll_PC;
      IF_flag <= 1'b0;
      if (r_state != IF_IDLE && mem_bus.mem_done) begin
        r_mem_req <= 1'b0;
        r_state   <= IF_IDLE;
      end else if (r_state == IF_WAIT) begin
        r_state <= IF_DISCARD;
      end
    end else begin
      IF_flag <= 1'b0;
      if (rdy) begin
        case (r_state)
          IF_IDLE: if (!IQ_full) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= IF_WAIT;
          end
          IF_WAIT: if (mem_bus.mem_done) begin
            r_mem_req      <= 1'b0;
            IF_flag        <= 1'b1;
            IF_inst        <= mem_bus.mem_inst;
            IF_PC          <= r_pc;
            IF_BTB_PC      <= w_next_pc;
            IF_BTB_predict <= w_predict;
            r_pc           <= w_next_pc;
            r_state        <= IF_IDLE;
          end
          IF_DISCARD: if (mem_bus.mem_done) begin
            r_mem_req <= 1'b0;
            r_state   <= IF_IDLE;
          end
          default: r_state <= IF_IDLE;
        endcase
      end
    end
  end

  // Issue waits for a free IQ slot, so a push into a full queue means the handshake broke.
  assert property (@(posedge clk) disable iff (!rst) !(IF_flag && IQ_full));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, IQ back-pressure, BTB training,
// roll/discard corner cases, rdy stalls and asynchronous reset.
module tb_inst_fetch;

  logic        clk, rst, rdy, roll, IQ_full;
  logic [31:0] roll_PC;
  logic        IF_flag, IF_BTB_predict;
  logic [31:0] IF_inst, IF_PC, IF_BTB_PC;
  logic        ROB_br_flag, ROB_br_taken;
  logic [31:0] ROB_br_PC, ROB_br_target;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_push = 0;
  int p0;
  logic seen;

  inst_fetch_if mem_if ();

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .roll           (roll),
    .roll_PC        (roll_PC),
    .mem_bus        (mem_if),
    .IQ_full        (IQ_full),
    .IF_flag        (IF_flag),
    .IF_inst        (IF_inst),
    .IF_PC          (IF_PC),
    .IF_BTB_PC      (IF_BTB_PC),
    .IF_BTB_predict (IF_BTB_predict),
    .ROB_br_flag    (ROB_br_flag),
    .ROB_br_PC      (ROB_br_PC),
    .ROB_br_target  (ROB_br_target),
    .ROB_br_taken   (ROB_br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (IF_flag === 1'b1) n_push++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %-18s got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] pc);
    int n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, mem_if.mem_req}, 32'd1);
    check("mem_addr", mem_if.mem_addr, pc);
  endtask

  // Serve one read after lat cycles and check the resulting push.
  task automatic fetch_one(input int lat, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] btb_pc, input logic pred);
    wait_req(pc);
    repeat (lat) tick();
    mem_if.mem_done = 1'b1;
    mem_if.mem_inst = inst;
    tick();
    mem_if.mem_done = 1'b0;
    mem_if.mem_inst = '0;
    check("push_flag", {31'b0, IF_flag}, 32'd1);
    check("push_inst", IF_inst, inst);
    check("push_pc", IF_PC, pc);
    check("push_btb_pc", IF_BTB_PC, btb_pc);
    check("push_predict", {31'b0, IF_BTB_predict}, {31'b0, pred});
  endtask

  task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    ROB_br_flag   = 1'b1;
    ROB_br_PC     = pc;
    ROB_br_target = tgt;
    ROB_br_taken  = taken;
    tick();
    ROB_br_flag   = 1'b0;
  endtask

  task automatic roll_idle(input logic [31:0] pc);
    roll    = 1'b1;
    roll_PC = pc;
    tick();
    roll    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; roll = 1'b0; roll_PC = '0; IQ_full = 1'b1;
    ROB_br_flag = 1'b0; ROB_br_PC = '0; ROB_br_target = '0; ROB_br_taken = 1'b0;
    mem_if.mem_done = 1'b0; mem_if.mem_inst = '0;
    repeat (2) tick();
    check("rst_req", {31'b0, mem_if.mem_req}, 32'd0);
    check("rst_addr", mem_if.mem_addr, 32'd0);
    check("rst_flag", {31'b0, IF_flag}, 32'd0);
    check("rst_if_pc", IF_PC, 32'd0);
    rst = 1'b1;

    // IQ full blocks issue; release issues at the current PC next cycle.
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (mem_if.mem_req) seen = 1'b1;
    end
    check("full_no_req", {31'b0, seen}, 32'd0);
    IQ_full = 1'b0;
    tick();
    check("req_after_full", {31'b0, mem_if.mem_req}, 32'd1);
    check("addr_after_full", mem_if.mem_addr, 32'd0);
    fetch_one(3, 32'h0000_0013, 32'h0, 32'h4, 1'b0);
    tick();
    check("no_back_to_back", {31'b0, IF_flag}, 32'd0);

    // Train 0x10 -> 0x40 taken twice, then walk the PC up to it.
    btb_upd(32'h10, 32'h40, 1'b1);
    btb_upd(32'h10, 32'h40, 1'b1);
    fetch_one(2, 32'h1111_0001, 32'h4, 32'h8, 1'b0);
    fetch_one(1, 32'h1111_0002, 32'h8, 32'hC, 1'b0);
    fetch_one(2, 32'h1111_0003, 32'hC, 32'h10, 1'b0);
    fetch_one(3, 32'h1111_0004, 32'h10, 32'h40, 1'b1);

    // Roll two cycles before the response: it must be discarded.
    wait_req(32'h40);
    p0 = n_push;
    tick();
    roll = 1'b1; roll_PC = 32'h100;
    tick();
    roll = 1'b0;
    check("discard_req_held", {31'b0, mem_if.mem_req}, 32'd1);
    check("discard_addr", mem_if.mem_addr, 32'h40);
    tick();
    mem_if.mem_done = 1'b1; mem_if.mem_inst = 32'hDEAD_0001;
    tick();
    mem_if.mem_done = 1'b0;
    check("discard_no_flag", {31'b0, IF_flag}, 32'd0);
    wait_req(32'h100);
    check("discard_pushes", n_push - p0, 32'd0);
    fetch_one(1, 32'h2222_0001, 32'h100, 32'h104, 1'b0);

    // Roll coinciding with the response drops it.
    wait_req(32'h104);
    p0 = n_push;
    tick();
    roll = 1'b1; roll_PC = 32'h200; mem_if.mem_done = 1'b1; mem_if.mem_inst = 32'hDEAD_0002;
    tick();
    roll = 1'b0; mem_if.mem_done = 1'b0;
    check("roll_done_flag", {31'b0, IF_flag}, 32'd0);
    check("roll_done_req", {31'b0, mem_if.mem_req}, 32'd0);
    wait_req(32'h200);

    // Second roll while discarding: the latest roll_PC wins.
    tick();
    roll = 1'b1; roll_PC = 32'h300;
    tick();
    roll = 1'b0;
    tick();
    roll = 1'b1; roll_PC = 32'h340;
    tick();
    roll = 1'b0;
    check("discard2_req_held", {31'b0, mem_if.mem_req}, 32'd1);
    tick();
    mem_if.mem_done = 1'b1; mem_if.mem_inst = 32'hDEAD_0003;
    tick();
    mem_if.mem_done = 1'b0;
    wait_req(32'h340);
    check("roll_pushes", n_push - p0, 32'd0);
    fetch_one(2, 32'h3333_0001, 32'h340, 32'h344, 1'b0);

    // rdy low in IDLE blocks issue; rdy low in WAIT holds the request.
    rdy = 1'b0;
    repeat (3) tick();
    check("rdy0_no_issue", {31'b0, mem_if.mem_req}, 32'd0);
    rdy = 1'b1;
    wait_req(32'h344);
    tick();
    rdy = 1'b0;
    p0 = n_push;
    repeat (3) tick();
    check("rdy0_req_held", {31'b0, mem_if.mem_req}, 32'd1);
    rdy = 1'b1;
    tick();
    mem_if.mem_done = 1'b1; mem_if.mem_inst = 32'h4444_0001;
    tick();
    mem_if.mem_done = 1'b0;
    check("rdy_push_pc", IF_PC, 32'h344);
    check("rdy_push_btb", IF_BTB_PC, 32'h348);
    tick();
    check("rdy_one_push", n_push - p0, 32'd1);
    fetch_one(1, 32'h4444_0002, 32'h348, 32'h34C, 1'b0);

    // Aliasing entry 0x64 evicts 0x24: lookup of 0x24 must miss.
    roll_idle(32'h24);
    btb_upd(32'h24, 32'h80, 1'b1);
    btb_upd(32'h64, 32'hC0, 1'b1);
    fetch_one(2, 32'h5555_0001, 32'h24, 32'h28, 1'b0);
    // Realloc to 10, saturate at 11, step down to 10: still taken.
    roll_idle(32'h24);
    btb_upd(32'h24, 32'h80, 1'b1);
    btb_upd(32'h24, 32'h80, 1'b1);
    btb_upd(32'h24, 32'h80, 1'b1);
    btb_upd(32'h24, 32'h80, 1'b0);
    fetch_one(2, 32'h5555_0002, 32'h24, 32'h80, 1'b1);
    // Three not-taken: 10 -> 01 -> 00 -> 00 (saturated low).
    roll_idle(32'h24);
    btb_upd(32'h24, 32'h80, 1'b0);
    btb_upd(32'h24, 32'h80, 1'b0);
    btb_upd(32'h24, 32'h80, 1'b0);
    fetch_one(2, 32'h5555_0003, 32'h24, 32'h28, 1'b0);

    // Asynchronous reset in the middle of a read.
    wait_req(32'h28);
    tick();
    #3 rst = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_if.mem_req}, 32'd0);
    check("arst_addr", mem_if.mem_addr, 32'd0);
    check("arst_if_pc", IF_PC, 32'd0);
    check("arst_if_inst", IF_inst, 32'd0);
    check("arst_btb_pc", IF_BTB_PC, 32'd0);
    #1;
    roll = 1'b1; roll_PC = 32'h10; rst = 1'b1;
    tick();
    roll = 1'b0;
    fetch_one(1, 32'h6666_0001, 32'h10, 32'h14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
